// File: rtl/sr_pulse_gen.sv
// Debounced set/reset buttons -> single fixed-width S or R pulse with a trailing gap, for a NOR SR latch.
// Latency: S/R rises DEBOUNCE_CYCLES+3 clks after a clean edge; requests arriving while busy are dropped.
module sr_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S,
    output logic R,
    output logic busy,
    output logic q_model,
    output logic conflict
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Bit 0 carries the set button, bit 1 the reset button, through the whole front end.
    logic [1:0]         btn_raw;
    logic [1:0]         sync_meta;
    logic [1:0]         sync_q;
    logic [1:0]         stable;
    logic [1:0]         stable_d;
    logic [1:0]         req;
    logic [1:0][DW-1:0] db_cnt;

    logic               set_req;
    logic               reset_req;

    state_t             state;
    logic [TW-1:0]      tcnt;

    assign btn_raw = {btn_reset, btn_set};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    // The stable value flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable   <= '0;
            stable_d <= '0;
            db_cnt   <= '0;
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= ~stable[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign req       = stable & ~stable_d;
    assign set_req   = req[0];
    assign reset_req = req[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tcnt     <= '0;
            S        <= 1'b0;
            R        <= 1'b0;
            busy     <= 1'b0;
            q_model  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            conflict <= set_req & reset_req;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (set_req && !reset_req) begin
                        state <= PULSE_S;
                        S     <= 1'b1;
                        busy  <= 1'b1;
                    end else if (reset_req && !set_req) begin
                        state <= PULSE_R;
                        R     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                PULSE_S, PULSE_R: begin
                    if (tcnt == PULSE_LAST) begin
                        state   <= GAP;
                        tcnt    <= '0;
                        S       <= 1'b0;
                        R       <= 1'b0;
                        q_model <= (state == PULSE_S);
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GAP: begin
                    if (tcnt == GAP_LAST) begin
                        state <= IDLE;
                        tcnt  <= '0;
                        busy  <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tcnt  <= '0;
                    S     <= 1'b0;
                    R     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Driving S and R together would put the downstream NOR latch in its forbidden state.
    assert property (@(posedge clk) disable iff (!rst_n) !(S && R));

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Bench for sr_pulse_gen: reset, clean-edge vector table, bounce/conflict/drop/reset sequences, random bouncing.
module tb_sr_pulse_gen;

    localparam int D = 4;
    localparam int P = 3;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_set = 1'b0;
    logic btn_reset = 1'b0;
    logic S, R, busy, q_model, conflict;

    int checks = 0;
    int failures = 0;

    int  s_rises, r_rises, conf_cnt, act_cycles;
    int  prun, irun;
    bit  seen, prev_s, prev_r;

    // Reference model: countdown-style view of the spec rules.
    bit [1:0] m_d1, m_d2, m_stable, m_rose;
    int       m_run [2];
    int       m_pl, m_gl;
    bit       m_kind, m_q, m_conf;

    typedef struct {
        logic bs, br, s, r, bz, q, cf;
    } vec_t;
    vec_t tbl [14];

    sr_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES   (P),
        .GAP_CYCLES     (G)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_set  (btn_set),
        .btn_reset(btn_reset),
        .S        (S),
        .R        (R),
        .busy     (busy),
        .q_model  (q_model),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_d1 = '0; m_d2 = '0; m_stable = '0; m_rose = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_pl = 0; m_gl = 0; m_kind = 0; m_q = 0; m_conf = 0;
    endfunction

    function automatic void model_step(input logic bs, input logic br);
        bit [1:0] raw, req, s;
        raw    = {br, bs};
        req    = m_rose;
        s      = m_d2;
        m_d2   = m_d1;
        m_d1   = raw;
        m_rose = '0;
        for (int b = 0; b < 2; b++) begin
            if (s[b] != m_stable[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_stable[b] = ~m_stable[b];
                    m_run[b]    = 0;
                    m_rose[b]   = m_stable[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_conf = req[0] & req[1];
        if (m_pl > 0) begin
            m_pl--;
            if (m_pl == 0) begin
                m_gl = G;
                m_q  = m_kind;
            end
        end else if (m_gl > 0) begin
            m_gl--;
        end else if (req[0] ^ req[1]) begin
            m_kind = req[0];
            m_pl   = P;
        end
    endfunction

    function automatic void clear_counts();
        s_rises = 0; r_rises = 0; conf_cnt = 0; act_cycles = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(btn_set, btn_reset);
        #1;
        chk("S",        int'(S),        int'(m_pl > 0 && m_kind));
        chk("R",        int'(R),        int'(m_pl > 0 && !m_kind));
        chk("busy",     int'(busy),     int'(m_pl > 0 || m_gl > 0));
        chk("q_model",  int'(q_model),  int'(m_q));
        chk("conflict", int'(conflict), int'(m_conf));
        if (!rst_n) begin
            prun = 0; irun = 0; seen = 0; prev_s = 0; prev_r = 0;
        end else begin
            if (S && !prev_s) s_rises++;
            if (R && !prev_r) r_rises++;
            if (conflict) conf_cnt++;
            if (S || R) act_cycles++;
            chk("s_and_r", int'(S && R), 0);
            if (S || R) begin
                if (prun == 0 && seen) chk("gap_len_ok", int'(irun >= G), 1);
                prun++;
            end else begin
                if (prun > 0) begin
                    chk("pulse_len", prun, P);
                    seen = 1;
                    irun = 0;
                end
                prun = 0;
                irun++;
            end
            prev_s = S;
            prev_r = R;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 14; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 6; i < 9; i++)  tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        model_reset();
        clear_counts();
        prun = 0; irun = 0; seen = 0; prev_s = 0; prev_r = 0;

        repeat (3) tick();
        chk("rst_S", int'(S), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_q", int'(q_model), 0);
        chk("rst_conflict", int'(conflict), 0);
        #4 rst_n = 1'b1;

        // Clean set edge: S for 3 cycles starting 7 edges later, then 2 gap cycles.
        for (int i = 0; i < 14; i++) begin
            btn_set   = tbl[i].bs;
            btn_reset = tbl[i].br;
            tick();
            chk($sformatf("tbl%0d_S", i),    int'(S),        int'(tbl[i].s));
            chk($sformatf("tbl%0d_R", i),    int'(R),        int'(tbl[i].r));
            chk($sformatf("tbl%0d_busy", i), int'(busy),     int'(tbl[i].bz));
            chk($sformatf("tbl%0d_q", i),    int'(q_model),  int'(tbl[i].q));
            chk($sformatf("tbl%0d_cf", i),   int'(conflict), int'(tbl[i].cf));
        end

        // Simultaneous set and reset.
        btn_set = 1'b0;
        repeat (12) tick();
        clear_counts();
        btn_set = 1'b1; btn_reset = 1'b1;
        repeat (20) tick();
        chk("conflict_strobes", conf_cnt, 1);
        chk("conflict_no_pulse", act_cycles, 0);
        chk("conflict_q_kept", int'(q_model), 1);

        // Bouncing reset button, then a clean hold.
        btn_set = 1'b0; btn_reset = 1'b0;
        repeat (12) tick();
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            btn_reset = (k % 2 == 0);
            repeat (2) tick();
        end
        chk("bounce_no_r", r_rises, 0);
        btn_reset = 1'b1;
        repeat (20) tick();
        chk("bounce_r_pulses", r_rises, 1);
        chk("bounce_s_pulses", s_rises, 0);
        chk("bounce_q", int'(q_model), 0);

        // Reset request lands while the S pulse is active and is dropped.
        btn_reset = 1'b0;
        repeat (12) tick();
        clear_counts();
        btn_set = 1'b1;
        repeat (3) tick();
        btn_reset = 1'b1;
        repeat (20) tick();
        chk("drop_s_pulses", s_rises, 1);
        chk("drop_r_pulses", r_rises, 0);
        chk("drop_q", int'(q_model), 1);

        // Async reset in the second S cycle, then re-detect of the held button.
        btn_set = 1'b0; btn_reset = 1'b0;
        repeat (12) tick();
        btn_set = 1'b1;
        repeat (7) tick();
        chk("pre_rst_S", int'(S), 1);
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("async_S", int'(S), 0);
        chk("async_R", int'(R), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_q", int'(q_model), 0);
        model_reset();
        repeat (3) tick();
        #4 rst_n = 1'b1;
        clear_counts();
        repeat (16) tick();
        chk("rerise_s_pulses", s_rises, 1);
        chk("rerise_q", int'(q_model), 1);

        // Random bouncing on both buttons.
        btn_set = 1'b0; btn_reset = 1'b0;
        repeat (12) tick();
        clear_counts();
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 11) == 0) btn_set = ~btn_set;
            if ($urandom_range(0, 11) == 0) btn_reset = ~btn_reset;
            tick();
        end
        chk("rand_activity", int'(s_rises > 0 && r_rises > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
